noc_packet_injector: RTL and testbench

NOC_PACKET_INJECTOR -- requirements
Module: noc_packet_injector

---
 rtl/noc_packet_injector.sv | 171 +++++++++++++++++
 tb/tb_noc_packet_injector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_injector.sv
// rtl/noc_packet_injector.sv - local word FIFO to dual-rail 4-phase NoC flit injector
//
// Purpose: buffers local words {last,dest,data} in a small FIFO and emits them
// as 9-bit dual-rail flits (one header per packet, one payload flit per word)
// using a return-to-zero handshake against an asynchronous router enable.
//
// Ports:
//   CLK        sole clock, rising edge
//   _RESET     asynchronous active-low reset
//   in_valid   local word offered
//   in_ready   registered FIFO-not-full
//   in_dest    destination, taken from the first word of a packet
//   in_data    payload byte
//   in_last    last word of packet
//   out_d1     dual-rail true rails
//   out_d0     dual-rail false rails
//   out_e      router enable (async): 1 = ready for data, 0 = data acknowledged
//   busy       packet in flight or FIFO non-empty
//   pkt_count  packets fully sent; live only with NOC_INJ_PKT_COUNT_EN defined
//
// Optional feature macro: NOC_INJ_PKT_COUNT_EN

module noc_packet_injector #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        _RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_dest,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic [8:0]  out_d1,
  output logic [8:0]  out_d0,
  input  logic        out_e,
  output logic        busy,
  output logic [15:0] pkt_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, HDR_SET, HDR_RST, PAY_WAIT, PAY_SET, PAY_RST
  } state_t;

  state_t                 state;
  logic [16:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_next;
  logic                   push;
  logic                   pop;
  logic                   empty;
  logic [16:0]            head;
  logic [SYNC_STAGES-1:0] sync;
  logic                   e_sync;
  logic                   cur_last;

  assign empty  = (count == '0);
  assign push   = in_valid && in_ready;
  // The payload word leaves the FIFO only once the receiver has acknowledged it.
  assign pop    = (state == PAY_SET) && !e_sync;
  assign head   = mem[rd_ptr];
  assign e_sync = sync[SYNC_STAGES-1];
  assign busy   = (state != IDLE) || !empty;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage has no reset; validity is tracked by count.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {in_last, in_dest, in_data};
  end

  // in_ready reflects fullness after this cycle's push/pop, so a pop in a full
  // cycle does not let a simultaneous push through.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      in_ready <= (count_next != CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) sync <= '0;
    else         sync <= {sync[SYNC_STAGES-2:0], out_e};
  end

  // Rails are registered and only loaded on entry to a SET state, so they hold
  // steady for the whole SET phase and drop to neutral on entry to RST.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state    <= IDLE;
      out_d1   <= '0;
      out_d0   <= '0;
      cur_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty && e_sync) begin
            state  <= HDR_SET;
            out_d1 <= {1'b1, head[15:8]};
            out_d0 <= ~{1'b1, head[15:8]};
          end
        end
        HDR_SET: begin
          if (!e_sync) begin
            state  <= HDR_RST;
            out_d1 <= '0;
            out_d0 <= '0;
          end
        end
        HDR_RST: begin
          if (e_sync) state <= PAY_WAIT;
        end
        PAY_WAIT: begin
          if (!empty) begin
            state    <= PAY_SET;
            out_d1   <= {1'b0, head[7:0]};
            out_d0   <= ~{1'b0, head[7:0]};
            cur_last <= head[16];
          end
        end
        PAY_SET: begin
          if (!e_sync) begin
            state  <= PAY_RST;
            out_d1 <= '0;
            out_d0 <= '0;
          end
        end
        PAY_RST: begin
          if (e_sync) state <= cur_last ? IDLE : PAY_WAIT;
        end
        default: begin
          state  <= IDLE;
          out_d1 <= '0;
          out_d0 <= '0;
        end
      endcase
    end
  end

`ifdef NOC_INJ_PKT_COUNT_EN
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      pkt_count <= '0;
    end else if (state == PAY_RST && e_sync && cur_last) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_noc_packet_injector.sv
// tb/tb_noc_packet_injector.sv - directed self-checking bench for noc_packet_injector

module tb_noc_packet_injector;

`ifdef NOC_INJ_PKT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_dest = '0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic [8:0]  out_d1;
  logic [8:0]  out_d0;
  logic        out_e = 1'b1;
  logic        busy;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;

  // receiver control (written by the initial block only)
  bit rx_en = 1'b0;
  int rx_delay = 0;

  // receiver / monitor state (written by their own always blocks only)
  logic [8:0] rx_q[$];
  int         runs[$];
  int         hold_cnt = 0;
  int         stable_viol = 0;
  bit         in_flit = 1'b0;
  logic [8:0] cur_flit = '0;
  int         run_len = 0;

  noc_packet_injector #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .CLK(clk), ._RESET(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data), .in_last(in_last),
    .out_d1(out_d1), .out_d0(out_d0), .out_e(out_e),
    .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // Four-phase receiver: acknowledge a complete code after rx_delay cycles,
  // re-enable once the rails return to neutral.
  always @(negedge clk) begin
    if (rx_en) begin
      if (out_e) begin
        if ((out_d1 ^ out_d0) == 9'h1FF) begin
          if (hold_cnt >= rx_delay) begin
            rx_q.push_back(out_d1);
            out_e = 1'b0;
            hold_cnt = 0;
          end else begin
            hold_cnt++;
          end
        end
      end else if (out_d1 == 9'h000 && out_d0 == 9'h000) begin
        out_e = 1'b1;
      end
    end else begin
      hold_cnt = 0;
    end
  end

  // Rail monitor: every sample is either neutral or a complete code, and a
  // complete code never changes until the rails go neutral.
  always @(negedge clk) begin
    if ((out_d1 ^ out_d0) == 9'h1FF) begin
      if (!in_flit) begin
        in_flit  = 1'b1;
        cur_flit = out_d1;
        run_len  = 1;
      end else begin
        if (out_d1 != cur_flit) stable_viol++;
        run_len++;
      end
    end else begin
      if (in_flit) runs.push_back(run_len);
      in_flit = 1'b0;
      if (out_d1 != 9'h000 || out_d0 != 9'h000) stable_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] x, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_dest = d; in_data = x; in_last = l;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("push_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check("idle_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  int base;
  int rbase;
  logic [8:0] exp_flits[$];

  initial begin
    // reset state
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_d1", out_d1, 0);
    check("rst_d0", out_d0, 0);
    check("rst_pkt_count", pkt_count, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_cycle_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);

    // single-word packet
    rx_en = 1'b1; rx_delay = 0;
    base = rx_q.size();
    push(8'hA5, 8'h3C, 1'b1);
    wait_idle(500);
    check("p1_nflits", rx_q.size() - base, 2);
    if (rx_q.size() - base == 2) begin
      check("p1_hdr", rx_q[base], 9'h1A5);
      check("p1_pay", rx_q[base+1], 9'h03C);
    end
    check("p1_pkt_count", pkt_count, exp_cnt(1));

    // fill FIFO while receiver stalls the header
    rx_en = 1'b0;
    base = rx_q.size();
    push(8'h11, 8'h01, 1'b0);
    push(8'h11, 8'h02, 1'b0);
    push(8'h11, 8'h03, 1'b0);
    push(8'h11, 8'h04, 1'b1);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_busy", busy, 1);
    in_valid = 1'b1; in_dest = 8'h11; in_data = 8'h55; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_5th_blocked", in_ready, 0);
    end
    in_valid = 1'b0;
    check("full_hdr_not_acked", rx_q.size() - base, 0);
    rx_en = 1'b1;
    wait_idle(1000);
    exp_flits = '{9'h111, 9'h001, 9'h002, 9'h003, 9'h004};
    check("full_nflits", rx_q.size() - base, 5);
    if (rx_q.size() - base == 5)
      for (int i = 0; i < 5; i++) check("full_order", rx_q[base+i], exp_flits[i]);
    check("full_pkt_count", pkt_count, exp_cnt(2));

    // starved FIFO mid-packet
    base = rx_q.size();
    push(8'h77, 8'h10, 1'b0);
    repeat (40) @(negedge clk);
    check("starve_d1", out_d1, 0);
    check("starve_d0", out_d0, 0);
    check("starve_busy", busy, 1);
    check("starve_nflits", rx_q.size() - base, 2);
    push(8'h77, 8'h20, 1'b0);
    push(8'h77, 8'h30, 1'b1);
    wait_idle(1000);
    exp_flits = '{9'h177, 9'h010, 9'h020, 9'h030};
    check("starve_total", rx_q.size() - base, 4);
    if (rx_q.size() - base == 4)
      for (int i = 0; i < 4; i++) check("starve_order", rx_q[base+i], exp_flits[i]);
    check("starve_pkt_count", pkt_count, exp_cnt(3));

    // slow receiver: rails held through a 50-cycle acknowledge delay
    rx_delay = 50;
    base  = rx_q.size();
    rbase = runs.size();
    push(8'h42, 8'h99, 1'b1);
    wait_idle(2000);
    check("slow_nflits", rx_q.size() - base, 2);
    if (rx_q.size() - base == 2) begin
      check("slow_hdr", rx_q[base], 9'h142);
      check("slow_pay", rx_q[base+1], 9'h099);
    end
    check("slow_nruns", runs.size() - rbase, 2);
    if (runs.size() - rbase == 2) begin
      check("slow_hdr_held", runs[rbase] >= 51, 1);
      check("slow_pay_held", runs[rbase+1] >= 51, 1);
    end
    check("rail_stability", stable_viol, 0);
    check("slow_pkt_count", pkt_count, exp_cnt(4));

    // reset while in PAY_SET
    rx_delay = 5;
    push(8'h5A, 8'hC3, 1'b1);
    begin
      int n = 0;
      while (out_d1 != 9'h0C3 && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (n >= 500) check("payset_timeout", 32'd1, 32'd0);
    end
    rx_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_d1", out_d1, 0);
    check("midrst_d0", out_d0, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pkt_count", pkt_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_d1", out_d1, 0);
    check("post_rst_d0", out_d0, 0);
    check("post_rst_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
